ex_data_pkt_reader: RTL and testbench
=====================================

// Module: ex_data_pkt_reader
// PURPOSE
//  Read side of the 8-bit ex_data prefetch FIFO. Drains bytes (rd_en/rd_vld, first-word-fall-through)
//  and emits framed packets on a valid/ready byte stream toward the tx packet path.
//  Frame format: 0xA5 sync byte, 8-bit sequence number, then 1..MAX_LEN payload bytes.
//  A packet closes on MAX_LEN bytes, or when the FIFO stays empty for IDLE_TMO cycles.
// PARAMETERS
//  MAX_LEN   1024  payload bytes per packet, 2..2048
//  IDLE_TMO  64    empty-FIFO cycles that close a partial packet, 1..65535
//  SYNC_BYTE 8'hA5 first header byte
// PORTS
//  clk          in   1  single clock; FIFO and stream share it
//  rst_n        in   1  asynchronous, active-low reset
//  en           in   1  1 = packets may start; sampled in IDLE only
//  fifo_rd_vld  in   1  FIFO head byte valid
//  fifo_rd_data in   8  FIFO head byte
//  fifo_rd_en   out  1  pop head byte; asserted only while fifo_rd_vld=1
//  tx_valid     out  1  stream byte valid
//  tx_data      out  8  stream byte
//  tx_last      out  1  final byte of packet; qualified by tx_valid
//  tx_ready     in   1  sink accepts when tx_valid & tx_ready
//  pkt_done     out  1  one-cycle pulse after the tx_last byte is accepted
//  seq_num      out  8  sequence number of the current/next packet
// BEHAVIOUR
//  Reset: state=IDLE; hold_vld=0; cnt=0; tmo_cnt=0; seq_num=0. All outputs 0.
//  Holding register: one payload byte (hold, hold_vld) plus cnt = payload index of hold (1..MAX_LEN).
//   The hold register gives one byte of lookahead, so tx_last is known when the byte is shown.
//  IDLE: en & fifo_rd_vld -> fifo_rd_en=1, hold<=data, cnt<=1, go HDR0. en=0 -> stay, no pops.
//  HDR0: tx_valid=1, tx_data=SYNC_BYTE, tx_last=0; on accept -> HDR1.
//  HDR1: tx_valid=1, tx_data=seq_num, tx_last=0; on accept -> PAYLOAD.
//  PAYLOAD: tx_data=hold.
//   end_cond = (cnt==MAX_LEN) | tmo_lat | (tmo_cnt==IDLE_TMO & !fifo_rd_vld).
//   tx_valid = hold_vld & (fifo_rd_vld | end_cond). tx_last = end_cond.
//   Accept with !tx_last: fifo_rd_en=1; hold<=fifo_rd_data; cnt++; tmo_cnt<=0.
//   Accept with tx_last: hold_vld<=0, seq_num++ (8-bit wrap 255->0), pkt_done=1 next cycle, go IDLE.
//   Payload is never popped outside HDR0/HDR1 lookahead: exactly one byte is popped per payload byte emitted.
//  Timeout: tmo_cnt increments in PAYLOAD while !fifo_rd_vld; saturates at IDLE_TMO; clears when fifo_rd_vld=1.
//   Data arriving in the same cycle tmo_cnt reaches IDLE_TMO wins (packet continues, tx_last=0).
//  Stability: once tx_valid=1, tx_data/tx_last hold until accepted. tmo_lat is set when a timeout tx_last
//   is first shown and stalled; it stays set until accept, so data arriving later cannot clear tx_last.
//  Latency: first FIFO byte to HDR0 tx_valid = 1 cycle. Back-to-back packets: one IDLE cycle between them.
//  FIFO full or empty are not visible here. An empty FIFO only stalls or times out; it is never an error.
//  rst_n asserted mid-packet: the packet is truncated with no tx_last. The sink must discard frames
//   without a tx_last. Held byte is lost; seq_num restarts at 0.
//  Widths: cnt = $clog2(MAX_LEN+1) bits; tmo_cnt = $clog2(IDLE_TMO+1) bits; no other arithmetic.
// STRUCTURE
//  ex_data_pkt_pkg: state enum {IDLE,HDR0,HDR1,PAYLOAD}; SYNC_BYTE default; header length constant (2).
//  One sub-module, ex_data_tmo_cnt: saturating counter with clear, enable and hit output.
//  Everything else is one FSM plus datapath in this file.
// TESTING
//  1) MAX_LEN=4, FIFO preloaded 0x10..0x17, tx_ready=1 -> A5,00,10,11,12,13(last); A5,01,14..17(last); pkt_done x2.
//  2) IDLE_TMO=8, 3 bytes 0x01..0x03 then FIFO empty -> A5,00,01,02; 03 with last exactly 8 cycles after last pop.
//  3) Byte arrives on the cycle tmo_cnt hits IDLE_TMO -> no tx_last, packet continues.
//     Byte arrives while a timeout last is stalled (tx_ready=0) -> tx_last stays 1, byte is left in the FIFO.
//  4) Random tx_ready backpressure, 2048 random bytes -> payload matches FIFO order, no drops or duplicates.
//     tx_data/tx_last are stable under stall; fifo_rd_en never asserts with fifo_rd_vld=0.
//  5) 257 packets -> seq_num wraps 0xFF->0x00; en=0 mid-packet -> packet completes, next one is not started.
//  6) rst_n low during PAYLOAD -> all outputs 0 asynchronously; after release, next frame starts A5,00.

Source files
------------

// File: rtl/ex_data_pkt_pkg.sv
// Shared types and constants for the ex_data packet reader.
// State encoding, default sync byte and header length.
package ex_data_pkt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StPayload
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned HDR_LEN       = 2;

endpackage

// File: rtl/ex_data_pkt_if.sv
// FIFO read port plus tx byte stream between the packet reader and its neighbours.
// master = the reader; slave = FIFO/sink side.
interface ex_data_pkt_if;

  logic       fifo_rd_vld;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    input  fifo_rd_vld, fifo_rd_data, tx_ready,
    output fifo_rd_en, tx_valid, tx_data, tx_last
  );

  modport slave (
    output fifo_rd_vld, fifo_rd_data, tx_ready,
    input  fifo_rd_en, tx_valid, tx_data, tx_last
  );

endinterface

// File: rtl/ex_data_tmo_cnt.sv
// Saturating idle counter: clear wins over enable, hit stays high once LIMIT is reached.
module ex_data_tmo_cnt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign hit = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_data_pkt_reader.sv
// Drains the ex_data FIFO and frames bytes as [sync, seq, payload...] on a valid/ready stream.
// One held payload byte gives the lookahead needed to flag tx_last when the byte is shown.
module ex_data_pkt_reader
  import ex_data_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 1024,
  parameter int unsigned IDLE_TMO  = 64,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  ex_data_pkt_if.master        bus,
  output logic                 pkt_done,
  output logic [7:0]           seq_num
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  state_e            state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        seq_q, seq_d;
  logic              tmo_lat_q, tmo_lat_d;
  logic              done_q, done_d;

  logic              tmo_hit, tmo_clr, tmo_en, end_cond;
  logic              rd_en, tx_valid, tx_last;
  logic [7:0]        tx_data;

  // Idle time only accumulates while a packet waits on an empty FIFO.
  assign tmo_clr = (state_q != StPayload) || bus.fifo_rd_vld;
  assign tmo_en  = (state_q == StPayload) && !bus.fifo_rd_vld;

  ex_data_tmo_cnt #(
    .LIMIT (IDLE_TMO)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .hit   (tmo_hit)
  );

  // Fresh data on the hit cycle keeps the packet open unless a timeout last is already latched.
  assign end_cond = (cnt_q == CntW'(MAX_LEN)) || tmo_lat_q || (tmo_hit && !bus.fifo_rd_vld);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    tmo_lat_d  = 1'b0;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && bus.fifo_rd_vld) begin
          rd_en      = 1'b1;
          hold_d     = bus.fifo_rd_data;
          hold_vld_d = 1'b1;
          cnt_d      = CntW'(1);
          state_d    = StHdr0;
        end
      end
      StHdr0: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (bus.tx_ready) state_d = StHdr1;
      end
      StHdr1: begin
        tx_valid = 1'b1;
        tx_data  = seq_q;
        if (bus.tx_ready) state_d = StPayload;
      end
      StPayload: begin
        tx_data  = hold_q;
        tx_last  = end_cond;
        tx_valid = hold_vld_q && (bus.fifo_rd_vld || end_cond);
        if (tx_valid && bus.tx_ready) begin
          if (end_cond) begin
            hold_vld_d = 1'b0;
            seq_d      = seq_q + 1'b1;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            rd_en  = 1'b1;
            hold_d = bus.fifo_rd_data;
            cnt_d  = cnt_q + 1'b1;
          end
        end else begin
          // Pin a shown last so late data cannot withdraw it before the sink takes it.
          tmo_lat_d = tx_valid && end_cond;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset gating keeps the pop strobe low while rst_n is asserted.
  assign bus.fifo_rd_en = rd_en && rst_n;
  assign bus.tx_valid   = tx_valid;
  assign bus.tx_data    = tx_data;
  assign bus.tx_last    = tx_last;
  assign pkt_done       = done_q;
  assign seq_num        = seq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
      seq_q      <= 8'h00;
      tmo_lat_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      tmo_lat_q  <= tmo_lat_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_data_pkt_reader.sv
// Directed and randomized bench for ex_data_pkt_reader with a queue-based FIFO and frame model.
module tb_ex_data_pkt_reader;
  import ex_data_pkt_pkg::*;

  localparam int unsigned MAX_LEN  = 4;
  localparam int unsigned IDLE_TMO = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       pkt_done;
  logic [7:0] seq_num;

  ex_data_pkt_if bus ();

  ex_data_pkt_reader #(
    .MAX_LEN   (MAX_LEN),
    .IDLE_TMO  (IDLE_TMO),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus),
    .pkt_done (pkt_done),
    .seq_num  (seq_num)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] pl_q[$];
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         m_seq    = 0;
  int         done_cnt = 0;
  int         base     = 0;
  int         n        = 0;
  int         e        = 0;
  bit         found    = 0;
  bit         rnd_ready  = 0;
  bit         pop_s      = 0;
  bit         stall_s    = 0;
  bit         last_acc_s = 0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_rd_vld  = (fifo_q.size() != 0);
    bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Sample in mid-cycle: stream/pop bookkeeping plus per-cycle protocol checks.
  task automatic at_neg();
    bit acc;
    @(negedge clk);
    if (stall_s) chk("stall_hold", {bus.tx_valid, bus.tx_last, bus.tx_data},
                     {1'b1, stall_last, stall_data});
    chk("pkt_done", pkt_done, last_acc_s);
    if (bus.fifo_rd_en) chk("rd_en_vld", bus.fifo_rd_vld, 1);
    pop_s = bus.fifo_rd_en && bus.fifo_rd_vld;
    acc   = bus.tx_valid && bus.tx_ready;
    if (acc) got_q.push_back({bus.tx_last, bus.tx_data});
    last_acc_s = acc && bus.tx_last;
    stall_s    = bus.tx_valid && !bus.tx_ready;
    stall_data = bus.tx_data;
    stall_last = bus.tx_last;
    if (pkt_done) done_cnt++;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    if (pop_s) void'(fifo_q.pop_front());
    pop_s = 0;
    if (rnd_ready) bus.tx_ready = 1'($urandom_range(0, 1));
    refresh();
  endtask

  task automatic step();
    at_neg();
    at_pos();
  endtask

  task automatic run_until_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, (done_cnt >= target), 1);
  endtask

  // Expected frame = sync, sequence number, then the payload with last on its final byte.
  task automatic expect_frame();
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'(m_seq)});
    for (int i = 0; i < pl_q.size(); i++) exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
    m_seq = (m_seq + 1) % 256;
    pl_q.delete();
  endtask

  task automatic compare_stream(input string tag);
    int lim;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      chk(tag, got_q[i], exp_q[i]);
      if (got_q[i] !== exp_q[i]) break;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Step until the pop that empties the FIFO has been seen.
  task automatic wait_last_pop(input string tag);
    bit lp;
    int k;
    lp = 0;
    k  = 0;
    while (!lp && k < 60) begin
      at_neg();
      lp = pop_s && (fifo_q.size() == 1);
      at_pos();
      k++;
    end
    chk(tag, lp, 1);
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    refresh();

    // Reset state
    step();
    at_neg();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_last", bus.tx_last, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_seq", seq_num, 0);
    at_pos();
    rst_n = 1'b1;

    // 1) MAX_LEN packets from a preloaded FIFO; en=0 holds everything back
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
    bus.tx_ready = 1'b1;
    refresh();
    repeat (3) step();
    chk("t1_en0_hold", fifo_q.size(), 8);
    en = 1'b1;
    at_neg();
    chk("t1_first_pop", bus.fifo_rd_en, 1);
    chk("t1_no_hdr_yet", bus.tx_valid, 0);
    at_pos();
    at_neg();
    chk("t1_hdr0", {bus.tx_valid, bus.tx_last, bus.tx_data}, {1'b1, 1'b0, 8'hA5});
    at_pos();
    base = done_cnt;
    run_until_done(base + 2, 100, "t1_done");
    chk("t1_bytes", got_q.size(), 2 * (HDR_LEN + MAX_LEN));
    for (int i = 0; i < 4; i++) pl_q.push_back(8'(8'h10 + i));
    expect_frame();
    for (int i = 4; i < 8; i++) pl_q.push_back(8'(8'h10 + i));
    expect_frame();
    compare_stream("t1_stream");
    chk("t1_seq", seq_num, 2);

    // 2) Partial packet closed after IDLE_TMO empty cycles
    for (int i = 1; i <= 3; i++) fifo_q.push_back(8'(i));
    refresh();
    wait_last_pop("t2_last_pop");
    found = 0;
    e = 0;
    while (!found && e < 40) begin
      at_neg();
      if (bus.tx_valid) begin
        found = 1;
        chk("t2_tmo_byte", {bus.tx_last, bus.tx_data}, {1'b1, 8'h03});
      end else begin
        e++;
      end
      at_pos();
    end
    chk("t2_tmo_cycles", e, IDLE_TMO);
    base = done_cnt;
    run_until_done(base + 1, 100, "t2_done");
    for (int i = 1; i <= 3; i++) pl_q.push_back(8'(i));
    expect_frame();
    compare_stream("t2_stream");

    // 3a) Data arriving on the hit cycle keeps the packet open
    fifo_q.push_back(8'h21);
    fifo_q.push_back(8'h22);
    refresh();
    wait_last_pop("t3a_last_pop");
    for (int k = 0; k < int'(IDLE_TMO); k++) begin
      at_neg();
      chk("t3a_wait", bus.tx_valid, 0);
      at_pos();
    end
    fifo_q.push_back(8'h23);
    refresh();
    at_neg();
    chk("t3a_race", {bus.tx_valid, bus.tx_last, bus.tx_data}, {1'b1, 1'b0, 8'h22});
    at_pos();
    base = done_cnt;
    run_until_done(base + 1, 100, "t3a_done");
    pl_q.push_back(8'h21);
    pl_q.push_back(8'h22);
    pl_q.push_back(8'h23);
    expect_frame();
    compare_stream("t3a_stream");

    // 3b) Data arriving while a timeout last is stalled stays in the FIFO
    fifo_q.push_back(8'h31);
    fifo_q.push_back(8'h32);
    refresh();
    wait_last_pop("t3b_last_pop");
    bus.tx_ready = 1'b0;
    found = 0;
    n = 0;
    while (!found && n < 40) begin
      at_neg();
      found = bus.tx_valid;
      at_pos();
      n++;
    end
    chk("t3b_shown", found, 1);
    fifo_q.push_back(8'h33);
    refresh();
    at_neg();
    chk("t3b_last_kept", {bus.tx_valid, bus.tx_last, bus.tx_data}, {1'b1, 1'b1, 8'h32});
    at_pos();
    repeat (3) step();
    chk("t3b_byte_left", fifo_q.size(), 1);
    bus.tx_ready = 1'b1;
    base = done_cnt;
    run_until_done(base + 2, 100, "t3b_done");
    pl_q.push_back(8'h31);
    pl_q.push_back(8'h32);
    expect_frame();
    pl_q.push_back(8'h33);
    expect_frame();
    compare_stream("t3b_stream");

    // 4) 2048 random bytes under random backpressure; seq_num wraps along the way
    rnd_ready = 1;
    for (int i = 0; i < 2048; i++) begin
      fifo_q.push_back(8'($urandom));
      pl_q.push_back(fifo_q[i]);
      if (pl_q.size() == MAX_LEN) expect_frame();
    end
    refresh();
    base = done_cnt;
    run_until_done(base + 2048 / MAX_LEN, 40000, "t4_done");
    rnd_ready = 0;
    bus.tx_ready = 1'b1;
    compare_stream("t4_stream");
    chk("t4_seq_wrap", seq_num, 8'(m_seq));
    chk("t4_fifo_empty", fifo_q.size(), 0);

    // 5) en dropped mid-packet: current packet completes, next is not started
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h51 + i));
    refresh();
    step();
    step();
    en = 1'b0;
    base = done_cnt;
    run_until_done(base + 1, 100, "t5_done");
    repeat (20) step();
    at_neg();
    chk("t5_idle", bus.tx_valid, 0);
    at_pos();
    chk("t5_held", fifo_q.size(), 2);
    chk("t5_no_start", done_cnt, base + 1);
    en = 1'b1;
    run_until_done(base + 2, 100, "t5_resume");
    for (int i = 0; i < 4; i++) pl_q.push_back(8'(8'h51 + i));
    expect_frame();
    pl_q.push_back(8'h55);
    pl_q.push_back(8'h56);
    expect_frame();
    compare_stream("t5_stream");

    // 6) Reset in PAYLOAD truncates the frame; sequence restarts at 0
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h61 + i));
    refresh();
    step();
    bus.tx_ready = 1'b1;
    step();
    step();
    bus.tx_ready = 1'b0;
    at_neg();
    chk("t6_payload", {bus.tx_valid, bus.tx_last, bus.tx_data}, {1'b1, 1'b0, 8'h61});
    at_pos();
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", bus.tx_valid, 0);
    chk("t6_rst_data", bus.tx_data, 0);
    chk("t6_rst_last", bus.tx_last, 0);
    chk("t6_rst_rd_en", bus.fifo_rd_en, 0);
    chk("t6_rst_done", pkt_done, 0);
    chk("t6_rst_seq", seq_num, 0);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'(m_seq)});
    m_seq      = 0;
    stall_s    = 0;
    last_acc_s = 0;
    pop_s      = 0;
    bus.tx_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk("t6_seq_restart", seq_num, 0);
    base = done_cnt;
    run_until_done(base + 1, 100, "t6_done");
    for (int i = 1; i < 4; i++) pl_q.push_back(8'(8'h61 + i));
    expect_frame();
    compare_stream("t6_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
